// File: rtl/mult_div_pkg.sv
// mult_div_pkg: state encoding and iteration count shared by the mult/div control.
package mult_div_pkg;
  localparam int W = 32;
  localparam int ITERATIONS = 32;
  typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DIVZ} state_t;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 Booth multiply and restoring divide sharing one 64-bit register.
module mult_div_unit
  import mult_div_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start_mult,
  input  logic         start_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag;
  logic booth_q, booth_d, is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic done_q, done_d, div0_q, div0_d;
  logic [W:0] bsum, rsh, rdiff;
  always_comb begin
    a_mag = a[W-1] ? -a : a;
    b_mag = b[W-1] ? -b : b;
    // 33-bit Booth sum so that subtracting 0x80000000 cannot overflow
    bsum = {acc_q[2*W-1], acc_q[2*W-1:W]}
         + (({acc_q[0], booth_q} == 2'b01) ? {m_q[W-1], m_q}
         :  ({acc_q[0], booth_q} == 2'b10) ? -{m_q[W-1], m_q} : {(W+1){1'b0}});
    rsh = acc_q[2*W-1:W-1];
    rdiff = rsh - {1'b0, m_q};
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d = m_q;
    booth_d = booth_q;
    is_div_d = is_div_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    div0_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d = MULT;
          cnt_d = '0;
          acc_d = {{W{1'b0}}, b};
          m_d = a;
          booth_d = 1'b0;
          is_div_d = 1'b0;
        end else if (start_div) begin
          state_d = (b == '0) ? DIVZ : DIV;
          cnt_d = '0;
          acc_d = {{W{1'b0}}, a_mag};
          m_d = b_mag;
          is_div_d = 1'b1;
          neg_q_d = a[W-1] ^ b[W-1];
          neg_r_d = a[W-1];
        end
      end
      MULT: begin
        acc_d = {bsum[W:1], bsum[0], acc_q[W-1:1]};
        booth_d = acc_q[0];
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(ITERATIONS - 1)) ? FINISH : MULT;
      end
      DIV: begin
        acc_d = {rdiff[W] ? rsh[W-1:0] : rdiff[W-1:0], acc_q[W-2:0], ~rdiff[W]};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(ITERATIONS - 1)) ? FINISH : DIV;
      end
      FINISH: begin
        hi_d = (is_div_q && neg_r_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        lo_d = (is_div_q && neg_q_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        done_d = 1'b1;
        state_d = IDLE;
      end
      DIVZ: begin
        div0_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      booth_q <= 1'b0;
      is_div_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q <= m_d;
      booth_q <= booth_d;
      is_div_q <= is_div_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end
  assign busy = (state_q == MULT) || (state_q == DIV);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a queue scoreboard checked by a separate output monitor.
module tb_mult_div_unit;
  logic clk = 1'b0, reset = 1'b1, start_mult = 1'b0, start_div = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div0;
  logic [31:0] hi, lo;
  typedef struct packed {logic z; logic [31:0] h; logic [31:0] l;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  logic [31:0] ph = '0, pl = '0;
  logic pr = 1'b1;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every done/div0, otherwise hi/lo must hold
  always @(negedge clk) begin
    if (done === 1'b1 || div0 === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: done=%b div0=%b while nothing pending", done, div0);
      end else begin
        e = q.pop_front();
        chk("kind{done,div0}", {62'd0, done, div0}, e.z ? 64'd1 : 64'd2);
        chk("hi", {32'd0, hi}, {32'd0, e.h});
        chk("lo", {32'd0, lo}, {32'd0, e.l});
      end
    end else if (!reset && !pr) begin
      chk("hold_hilo", {hi, lo}, {ph, pl});
    end
    ph <= hi;
    pl <= lo;
    pr <= reset;
  end

  // Called at posedge+#1; returns at posedge+#1 after the result (or timeout).
  task automatic run(input bit is_div, input bit both, input bit glitch,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eh, input logic [31:0] el, input bit ez);
    int lat;
    q.push_back({ez, eh, el});
    start_mult = !is_div || both;
    start_div = is_div || both;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div = 1'b0;
    a = $urandom;
    b = $urandom;
    chk("busy_after_start", {63'd0, busy}, {63'd0, !ez});
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      chk("busy", {63'd0, busy}, {63'd0, (!ez && c < 32)});
      start_div = glitch && (c == 10);
      if (glitch && c == 10) begin
        a = 32'd100;
        b = 32'd7;
      end
      if (done === 1'b1 || div0 === 1'b1) begin
        lat = c;
        break;
      end
    end
    start_div = 1'b0;
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no result within 40 cycles, expected one");
    end else begin
      chk("latency", 64'(lat), ez ? 64'd1 : 64'd33);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, busy, done, div0, hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(0, 0, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run(0, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0);
    run(0, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
    run(1, 0, 0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run(1, 0, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run(1, 0, 0, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 0);
    run(1, 0, 0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14, 0);
    // 1628201331 * 805654952 = 0x12345678_12345678
    run(0, 0, 0, 32'd1628201331, 32'd805654952, 32'h12345678, 32'h12345678, 0);
    run(1, 0, 0, 32'd5, 32'd0, 32'h12345678, 32'h12345678, 1);
    run(1, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run(0, 1, 0, 32'd6, 32'd7, 32'd0, 32'd42, 0);
    run(0, 0, 1, 32'hFFFFFFF6, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFA6, 0);
    // abort a multiply at iteration 10
    start_mult = 1'b1;
    a = 32'd3;
    b = 32'd5;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_state", {29'd0, busy, done, div0, hi, lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run(1, 0, 0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
